// File: rtl/uart_pkg.sv
// Shared definitions for the buffered Wishbone UART: register map, STAT bit
// positions, serial FSM state encodings and the divisor clamp helper.
package uart_pkg;

    localparam logic [7:0] ADR_DATA = 8'h00;
    localparam logic [7:0] ADR_STAT = 8'h04;
    localparam logic [7:0] ADR_DIV  = 8'h08;
    localparam logic [7:0] ADR_IEN  = 8'h0C;

    localparam int STAT_RX_NE   = 0;
    localparam int STAT_OVR     = 1;
    localparam int STAT_FERR    = 2;
    localparam int STAT_TX_NF   = 5;
    localparam int STAT_TX_IDLE = 6;

    localparam logic [15:0] DIV_MIN = 16'd7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is dropped
// unless a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/uart_fifo_controller.sv
// Wishbone-slave 8N1 UART with programmable divisor, TX/RX FIFOs, sticky
// error flags and a registered level interrupt.
module uart_fifo_controller
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_FREQ   = 90_000_000,
    parameter int BAUD       = 115200,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    output logic                    wb_ack_o,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    output logic                    uart_txd_o,
    input  logic                    uart_rxd_i,
    output logic                    irq_o
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / BAUD - 1);

    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d, rd_val;
    logic [15:0]           div_q, div_d, div_wr;
    logic [2:0]            ien_q, ien_d;
    logic                  ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
    logic                  req, rd_req, wr_req, stat_rd;
    logic [7:0]            adr;

    logic                  tx_push, tx_pop, tx_full, tx_empty, tx_idle;
    logic [7:0]            tx_rdata;
    logic [TX_CW-1:0]      tx_count;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]            rx_rdata;
    logic [RX_CW-1:0]      rx_count;

    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        txd_q;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q, rx_half;
    logic [16:0] rx_div_p1;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q;
    logic [1:0]  sync_q;
    logic        rxd_s, rx_stop_done, ovr_set, ferr_set;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[ADDR_WIDTH-1:8], wb_dat_i[DATA_WIDTH-1:16],
                           wb_sel_i[DATA_WIDTH/8-1:2], tx_count};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(tx_push), .pop_i(tx_pop),
        .wdata_i(wb_dat_i[7:0]), .rdata_o(tx_rdata), .full_o(tx_full),
        .empty_o(tx_empty), .count_o(tx_count)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_ni(rst_ni), .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_shift_q), .rdata_o(rx_rdata), .full_o(rx_full),
        .empty_o(rx_empty), .count_o(rx_count)
    );

    assign rxd_s        = sync_q[1];
    assign rx_div_p1    = {1'b0, rx_div_q} + 17'd1;
    assign rx_half      = rx_div_p1[16:1] - 16'd1;
    assign rx_stop_done = (rx_state_q == RX_STOP) && (rx_cnt_q == rx_div_q);
    assign rx_push      = rx_stop_done && rxd_s;
    assign ovr_set      = rx_push && rx_full && !rx_pop;
    assign ferr_set     = rx_stop_done && !rxd_s;
    assign tx_idle      = tx_empty && (tx_state_q == TX_IDLE);
    assign tx_pop       = !tx_empty && ((tx_state_q == TX_IDLE) ||
                          ((tx_state_q == TX_STOP) && (tx_cnt_q == tx_div_q)));

    always_comb begin
        adr     = wb_adr_i[7:0];
        req     = wb_cyc_i && wb_stb_i && !ack_q;
        rd_req  = req && !wb_we_i;
        wr_req  = req && wb_we_i;
        stat_rd = rd_req && (adr == ADR_STAT);
        tx_push = wr_req && (adr == ADR_DATA) && wb_sel_i[0];
        rx_pop  = rd_req && (adr == ADR_DATA) && !rx_empty;

        rd_val = '0;
        case (adr)
            ADR_DATA: if (!rx_empty) rd_val[7:0] = rx_rdata;
            ADR_STAT: begin
                rd_val[STAT_RX_NE]   = !rx_empty;
                rd_val[STAT_OVR]     = ovr_q;
                rd_val[STAT_FERR]    = ferr_q;
                rd_val[STAT_TX_NF]   = !tx_full;
                rd_val[STAT_TX_IDLE] = tx_idle;
                rd_val[15:8]         = 8'(rx_count);
            end
            ADR_DIV:  rd_val[15:0] = div_q;
            ADR_IEN:  rd_val[2:0]  = ien_q;
            default:  ;
        endcase

        div_wr = div_q;
        if (wb_sel_i[0]) div_wr[7:0]  = wb_dat_i[7:0];
        if (wb_sel_i[1]) div_wr[15:8] = wb_dat_i[15:8];
        div_d = div_q;
        if (wr_req && (adr == ADR_DIV) && (wb_sel_i[1:0] != 2'b00)) div_d = clamp_div(div_wr);

        ien_d = ien_q;
        if (wr_req && (adr == ADR_IEN) && wb_sel_i[0]) ien_d = wb_dat_i[2:0];

        // A fresh error in the clearing cycle wins over the clear.
        ovr_d  = (ovr_q  && !stat_rd) || ovr_set;
        ferr_d = (ferr_q && !stat_rd) || ferr_set;

        irq_d = |(ien_q & {ovr_q || ferr_q, tx_empty, !rx_empty});
        ack_d = req;
        dat_d = rd_req ? rd_val : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            div_q  <= DIV_RST;
            ien_q  <= '0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            div_q  <= div_d;
            ien_q  <= ien_d;
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
            irq_q  <= irq_d;
        end
    end

    // Transmitter: the next byte is loaded at the end of STOP, so frames run back to back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    txd_q    <= 1'b1;
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= tx_rdata;
                        tx_div_q   <= div_q;
                        txd_q      <= 1'b0;
                    end
                end
                TX_START: if (tx_cnt_q == tx_div_q) begin
                    tx_cnt_q   <= '0;
                    tx_bit_q   <= '0;
                    tx_state_q <= TX_DATA;
                    txd_q      <= tx_shift_q[0];
                end
                TX_DATA: if (tx_cnt_q == tx_div_q) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= TX_STOP;
                        txd_q      <= 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        tx_shift_q <= tx_shift_q >> 1;
                        txd_q      <= tx_shift_q[1];
                    end
                end
                TX_STOP: if (tx_cnt_q == tx_div_q) begin
                    tx_cnt_q <= '0;
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= tx_rdata;
                        tx_div_q   <= div_q;
                        txd_q      <= 1'b0;
                    end else begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Receiver: sample points sit mid-bit, offset by half a bit from the start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], uart_rxd_i};
            rx_cnt_q <= rx_cnt_q + 16'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rxd_s) begin
                        rx_state_q <= RX_START;
                        rx_div_q   <= div_q;
                    end
                end
                RX_START: if (rx_cnt_q == rx_half) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rxd_s ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= {rxd_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    else                  rx_bit_q   <= rx_bit_q + 3'd1;
                end
                RX_STOP: if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_q   <= '0;
                    rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign uart_txd_o = txd_q;
    assign irq_o      = irq_q;

endmodule
